// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: drives scan-enable, scan-in and increment of an external
// up-counter through a load / run / unload self-test sequence. The previous
// counter contents and the post-run result are captured, and the result is
// compared against (pattern + run cycles) mod 2^CHAIN_LEN.
module scan_test_ctrl #(
   parameter int CHAIN_LEN = 4,
   parameter int RUN_W     = 4
) (
   input  logic                 BrdClk,
   input  logic                 aReset_n,
   input  logic                 aStart,
   input  logic [CHAIN_LEN-1:0] aPattern,
   input  logic [RUN_W-1:0]     aRunCycles,
   input  logic                 aIncReq,
   input  logic                 bScanOut,
   output logic                 oScanEn,
   output logic                 oScanIn,
   output logic                 oIncrement,
   output logic                 oBusy,
   output logic                 oDone,
   output logic [CHAIN_LEN-1:0] oPrevState,
   output logic [CHAIN_LEN-1:0] oCapture,
   output logic                 oMatch
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] RUN    = 3'd2;
   localparam logic [2:0] UNLOAD = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam int              CNT_W      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

   logic [2:0]           state;
   logic [CHAIN_LEN-1:0] pattern_sr;   // remaining seed bits, MSB is next to shift
   logic [CHAIN_LEN-1:0] expected;
   logic [RUN_W-1:0]     run_n;
   logic [RUN_W-1:0]     run_cnt;
   logic [CNT_W-1:0]     shift_cnt;
   logic                 last_shift;
   logic [CHAIN_LEN-1:0] capture_shift;

   // Shift-position decode and the capture value after this edge's sample
   always_comb begin
      last_shift    = (shift_cnt == LAST_SHIFT);
      capture_shift = {oCapture[CHAIN_LEN-2:0], bScanOut};
   end

   // Sequencer: state, latched test parameters and all registered outputs
   always_ff @(posedge BrdClk or negedge aReset_n) begin
      if (!aReset_n) begin
         state      <= IDLE;
         pattern_sr <= '0;
         expected   <= '0;
         run_n      <= '0;
         run_cnt    <= '0;
         shift_cnt  <= '0;
         oScanEn    <= 1'b0;
         oScanIn    <= 1'b0;
         oIncrement <= 1'b0;
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
         oPrevState <= '0;
         oCapture   <= '0;
         oMatch     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               oDone <= 1'b0;
               if (aStart) begin
                  // start wins over a simultaneous increment request
                  state      <= LOAD;
                  pattern_sr <= aPattern;
                  run_n      <= aRunCycles;
                  expected   <= aPattern + CHAIN_LEN'(aRunCycles);
                  shift_cnt  <= '0;
                  oScanEn    <= 1'b1;
                  oScanIn    <= aPattern[CHAIN_LEN-1];
                  oIncrement <= 1'b0;
                  oBusy      <= 1'b1;
               end else begin
                  oScanEn    <= 1'b0;
                  oScanIn    <= 1'b0;
                  oIncrement <= aIncReq;
               end
            end
            LOAD: begin
               oPrevState <= {oPrevState[CHAIN_LEN-2:0], bScanOut};
               if (last_shift) begin
                  shift_cnt <= '0;
                  oScanIn   <= 1'b0;
                  if (run_n == '0) begin
                     // zero run cycles: go straight to unloading
                     state <= UNLOAD;
                  end else begin
                     state      <= RUN;
                     run_cnt    <= run_n - 1'b1;
                     oScanEn    <= 1'b0;
                     oIncrement <= 1'b1;
                  end
               end else begin
                  shift_cnt  <= shift_cnt + 1'b1;
                  pattern_sr <= {pattern_sr[CHAIN_LEN-2:0], 1'b0};
                  oScanIn    <= pattern_sr[CHAIN_LEN-2];
               end
            end
            RUN: begin
               if (run_cnt == '0) begin
                  state      <= UNLOAD;
                  oIncrement <= 1'b0;
                  oScanEn    <= 1'b1;
                  oScanIn    <= 1'b0;
               end else begin
                  run_cnt <= run_cnt - 1'b1;
               end
            end
            UNLOAD: begin
               oCapture <= capture_shift;
               if (last_shift) begin
                  state     <= DONE;
                  shift_cnt <= '0;
                  oScanEn   <= 1'b0;
                  oDone     <= 1'b1;
                  oMatch    <= (capture_shift == expected);
               end else begin
                  shift_cnt <= shift_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               oDone <= 1'b0;
               oBusy <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               oScanEn    <= 1'b0;
               oScanIn    <= 1'b0;
               oIncrement <= 1'b0;
               oBusy      <= 1'b0;
               oDone      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl: drives scan_test_ctrl against a behavioural 4-bit
// scannable up-counter; checks each sequence cycle by cycle against the
// timing rules, and the captured values against plain arithmetic.
module tb_scan_test_ctrl;

   logic       BrdClk;
   logic       aReset_n;
   logic       aStart;
   logic [3:0] aPattern;
   logic [3:0] aRunCycles;
   logic       aIncReq;
   logic       bScanOut;
   logic       oScanEn;
   logic       oScanIn;
   logic       oIncrement;
   logic       oBusy;
   logic       oDone;
   logic [3:0] oPrevState;
   logic [3:0] oCapture;
   logic       oMatch;

   int n_checks = 0;
   int n_fail   = 0;

   scan_test_ctrl #(.CHAIN_LEN(4), .RUN_W(4)) dut (
      .BrdClk     (BrdClk),
      .aReset_n   (aReset_n),
      .aStart     (aStart),
      .aPattern   (aPattern),
      .aRunCycles (aRunCycles),
      .aIncReq    (aIncReq),
      .bScanOut   (bScanOut),
      .oScanEn    (oScanEn),
      .oScanIn    (oScanIn),
      .oIncrement (oIncrement),
      .oBusy      (oBusy),
      .oDone      (oDone),
      .oPrevState (oPrevState),
      .oCapture   (oCapture),
      .oMatch     (oMatch)
   );

   initial BrdClk = 1'b0;
   always #5 BrdClk = ~BrdClk;

   // Behavioural counter under test: scan shift has priority over increment
   logic [3:0] cnt = 4'h0;
   logic       preset_req = 1'b0;
   logic [3:0] preset_val = 4'h0;
   bit         broken = 1'b0;   // models a counter whose increment is dead
   assign bScanOut = cnt[3];

   always @(posedge BrdClk) begin
      if (preset_req)               cnt <= preset_val;
      else if (oScanEn)             cnt <= {cnt[2:0], oScanIn};
      else if (oIncrement && !broken) cnt <= cnt + 4'h1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] all_outs();
      return {oScanEn, oScanIn, oIncrement, oBusy, oDone, oMatch, oPrevState, oCapture};
   endfunction

   task automatic preset(input logic [3:0] v);
      preset_val = v;
      preset_req = 1'b1;
      @(posedge BrdClk); #1;
      preset_req = 1'b0;
   endtask

   // Full test sequence; entered and left at 1 time unit after a rising edge.
   task automatic run_seq(input logic [3:0] pat, input logic [3:0] n,
                          input logic [3:0] exp_prev, input logic [3:0] exp_cap,
                          input logic exp_match, input bit noise,
                          input bit inc_with_start, input string name);
      int nn;
      logic [4:0] exp_v;
      int done_seen;
      nn = int'(n);
      done_seen = 0;
      aStart = 1'b1; aPattern = pat; aRunCycles = n; aIncReq = inc_with_start;
      @(posedge BrdClk); #1;   // E0
      aStart = 1'b0; aIncReq = 1'b0;
      for (int c = 0; c <= 9 + nn; c++) begin
         // expected {busy, scan_en, scan_in, increment, done} for cycle Ec..Ec+1
         if (c < 4)            exp_v = {1'b1, 1'b1, pat[3-c], 1'b0, 1'b0};
         else if (c < 4 + nn)  exp_v = 5'b10010;
         else if (c < 8 + nn)  exp_v = 5'b11000;
         else if (c == 8 + nn) exp_v = 5'b10001;
         else                  exp_v = 5'b00000;
         n_checks++;
         if ({oBusy, oScanEn, oScanIn, oIncrement, oDone} !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b (busy,en,in,inc,done)",
                     name, c, {oBusy, oScanEn, oScanIn, oIncrement, oDone}, exp_v);
         end
         if (oDone) done_seen++;
         if (c == 4) check({name, " prev_after_load"}, 16'(oPrevState), 16'(exp_prev));
         if (c == 8 + nn) begin
            check({name, " capture"}, 16'(oCapture), 16'(exp_cap));
            check({name, " match"},   16'(oMatch),   16'(exp_match));
         end
         if (noise && c < 9 + nn) begin
            aStart = 1'($urandom); aIncReq = 1'($urandom);
            aPattern = 4'($urandom); aRunCycles = 4'($urandom);
         end else begin
            aStart = 1'b0; aIncReq = 1'b0;
         end
         @(posedge BrdClk); #1;
      end
      check({name, " done_pulses"}, 16'(done_seen), 16'd1);
      check({name, " held_capture"}, 16'({oPrevState, oCapture, 3'b000, oMatch}),
            16'({exp_prev, exp_cap, 3'b000, exp_match}));
      check({name, " counter_cleared"}, 16'(cnt), 16'h0);
      $display("txn %s: pat=%h n=%0d prev=%h cap=%h match=%b", name, pat, n, oPrevState, oCapture, oMatch);
   endtask

   typedef struct {
      logic [3:0] preset;
      logic [3:0] pat;
      logic [3:0] n;
      logic [3:0] exp_prev;
      logic [3:0] exp_cap;
      logic       exp_match;
      bit         broken;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [3:0] p, pat, n, k;
      bit noise;
      int dones;

      tbl[0] = '{4'h0, 4'hA, 4'd3,  4'h0, 4'hD, 1'b1, 1'b0};  // basic
      tbl[1] = '{4'h0, 4'hF, 4'd2,  4'h0, 4'h1, 1'b1, 1'b0};  // wrap
      tbl[2] = '{4'h0, 4'h6, 4'd0,  4'h0, 4'h6, 1'b1, 1'b0};  // N=0
      tbl[3] = '{4'h9, 4'h0, 4'd15, 4'h9, 4'hF, 1'b1, 1'b0};  // max N
      tbl[4] = '{4'h3, 4'h8, 4'd8,  4'h3, 4'h0, 1'b1, 1'b0};  // wrap to 0
      tbl[5] = '{4'h5, 4'h4, 4'd2,  4'h5, 4'h4, 1'b0, 1'b1};  // dead counter

      aReset_n = 1'b0; aStart = 1'b0; aPattern = 4'h0; aRunCycles = 4'h0; aIncReq = 1'b0;
      #3;
      check("reset_outputs_before_edge", all_outs(), 16'h0);
      #9 aReset_n = 1'b1;           // released at t=12, between edges
      @(posedge BrdClk); #1;
      check("idle_after_reset", all_outs(), 16'h0);

      for (int i = 0; i < 6; i++) begin
         broken = tbl[i].broken;
         preset(tbl[i].preset);
         run_seq(tbl[i].pat, tbl[i].n, tbl[i].exp_prev, tbl[i].exp_cap,
                 tbl[i].exp_match, 1'b0, 1'b0, $sformatf("tbl%0d", i));
      end
      broken = 1'b0;

      // idle increments with one-cycle latency, then a start
      aIncReq = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge BrdClk); #1;
         check("idle_increment", 16'(oIncrement), 16'h1);
      end
      run_seq(4'h2, 4'd1, 4'h5, 4'h3, 1'b1, 1'b1, 1'b0, "idle_inc");

      // start and increment request together: start wins
      preset(4'h2);
      run_seq(4'h7, 4'd1, 4'h2, 4'h8, 1'b1, 1'b0, 1'b1, "start_wins");

      // asynchronous reset between edges while outputs are non-zero
      aIncReq = 1'b1;
      @(posedge BrdClk); #1;
      check("inc_before_reset", 16'(oIncrement), 16'h1);
      #2 aReset_n = 1'b0;
      #1 check("async_reset_idle", all_outs(), 16'h0);
      aIncReq = 1'b0;
      @(negedge BrdClk); aReset_n = 1'b1;
      @(posedge BrdClk); #1;
      $display("txn async_reset_idle: outputs=%h", all_outs());

      // reset in the middle of RUN
      preset(4'h0);
      aStart = 1'b1; aPattern = 4'h1; aRunCycles = 4'd6;
      @(posedge BrdClk); #1;
      aStart = 1'b0;
      repeat (5) begin @(posedge BrdClk); #1; end
      check("run_in_progress", 16'({oBusy, oScanEn, oIncrement}), 16'b101);
      #2 aReset_n = 1'b0;
      #1 check("abort_outputs", all_outs(), 16'h0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) begin @(negedge BrdClk); aReset_n = 1'b1; end
         @(posedge BrdClk); #1;
         if (oDone || oBusy) dones++;
      end
      check("abort_no_done", 16'(dones), 16'h0);
      $display("txn abort: busy/done cycles after abort=%0d", dones);
      preset(4'hC);
      run_seq(4'h3, 4'd4, 4'hC, 4'h7, 1'b1, 1'b0, 1'b0, "after_abort");

      // randomized sequences checked against arithmetic expectations
      for (int i = 0; i < 20; i++) begin
         p = 4'($urandom); pat = 4'($urandom); n = 4'($urandom_range(0, 15));
         noise = 1'($urandom);
         preset(p);
         k = 4'h0;
         if ($urandom_range(0, 1) == 1) begin
            k = 4'($urandom_range(1, 6));
            aIncReq = 1'b1;
            repeat (int'(k)) begin @(posedge BrdClk); #1; end
         end
         run_seq(pat, n, p + k, pat + n, 1'b1, noise, 1'b0, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scan_test_ctrl.md
SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 4: scan chain length and counter width of the controlled up-counter.
REQ-002 SHALL have parameter RUN_W, default 4: width of the run-cycle count.
REQ-003 SHALL have port BrdClk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port aReset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port aStart, input, 1: test request, sampled only in IDLE.
REQ-006 SHALL have port aPattern, input, CHAIN_LEN: seed value to load into the counter chain.
REQ-007 SHALL have port aRunCycles, input, RUN_W: number of functional increment cycles (N).
REQ-008 SHALL have port aIncReq, input, 1: functional increment request, honoured only in IDLE.
REQ-009 SHALL have port bScanOut, input, 1: counter chain tail, which is counter MSB.
REQ-010 SHALL have ports oScanEn, oScanIn and oIncrement, each an output of width 1, which drive the counter's scan-enable, scan-in and increment inputs.
REQ-011 SHALL have port oBusy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port oDone, output, 1: a one-cycle completion pulse.
REQ-013 SHALL have ports oPrevState and oCapture, outputs, each CHAIN_LEN wide: the chain contents unloaded during LOAD and during UNLOAD respectively.
REQ-014 SHALL have port oMatch, output, 1: oCapture equals expected value; valid while oDone is high.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, UNLOAD and DONE, with all outputs registered.
REQ-016 IDLE: when aStart=1 at edge E0, SHALL latch aPattern, aRunCycles and expected=(aPattern+aRunCycles) mod 2^CHAIN_LEN, then enter LOAD.
REQ-017 LOAD: SHALL hold for exactly CHAIN_LEN cycles with oScanEn=1 and oIncrement=0; on shift k (k=0..CHAIN_LEN-1), oScanIn=pattern[CHAIN_LEN-1-k], MSB first.
REQ-018 LOAD: SHALL sample bScanOut on each of the CHAIN_LEN shift edges (E1..E4) into oPrevState via a left shift, {prev[CHAIN_LEN-2:0], bScanOut}.
REQ-019 RUN: SHALL hold for exactly N cycles with oScanEn=0 and oIncrement=1; if N=0, RUN SHALL be skipped, so LOAD goes directly to UNLOAD.
REQ-020 UNLOAD: SHALL hold for exactly CHAIN_LEN cycles with oScanEn=1, oScanIn=0 and oIncrement=0, sampling bScanOut into oCapture with the same left-shift rule; the counter is therefore left at 0.
REQ-021 DONE: SHALL last one cycle, with oDone=1, oMatch=(oCapture==expected) and all counter drives 0, then enter IDLE.
REQ-022 Timing, with E0 as the start-sampling edge: LOAD spans E0..E4, RUN spans E4..E(4+N), UNLOAD spans E(4+N)..E(8+N), and oDone is high from E(8+N) to E(9+N).
REQ-023 IDLE: SHALL set oIncrement to the value of aIncReq registered at the previous edge (one-cycle latency), with oScanEn=0 and oScanIn=0.
REQ-024 If aStart and aIncReq are both high in IDLE, aStart SHALL win: oIncrement=0 on the next cycle.
REQ-025 SHALL ignore aStart and aIncReq in every state except IDLE; aPattern and aRunCycles SHALL only be used as latched.
REQ-026 oCapture, oPrevState and oMatch SHALL hold their values until the next LOAD or UNLOAD overwrites them.
REQ-027 Counter arithmetic SHALL wrap modulo 2^CHAIN_LEN; the RUN cycle count SHALL use a RUN_W-bit down-counter.

Reset
REQ-028 When aReset_n=0, the block SHALL immediately enter IDLE and drive all outputs and registers to 0, regardless of clock.
REQ-029 Reset mid-operation SHALL abort the sequence with no oDone pulse; after release, the next aStart SHALL begin a full sequence.
REQ-030 The counter's own reset SHALL remain the system's responsibility; this block SHALL NOT drive it.

Verification
REQ-031 Reset: aReset_n=0 asynchronously between edges -> all outputs 0 before the next edge.
REQ-032 Counter=0, aPattern=4'b1010, aRunCycles=3 -> oScanIn sequence 1,0,1,0; then 3 cycles of oIncrement; oPrevState=4'h0, oCapture=4'hD, oMatch=1, oDone high at E11 only.
REQ-033 Wrap: aPattern=4'hF, aRunCycles=2 -> oCapture=4'h1, oMatch=1.
REQ-034 N=0: aPattern=4'h6, aRunCycles=0 -> oIncrement never asserted, oCapture=4'h6, oDone at E8.
REQ-035 Idle increments and ignored inputs: after a run, aIncReq=1 for 5 cycles, then aStart with aPattern=4'h2, aRunCycles=1 -> oPrevState=4'h5, oCapture=4'h3; aStart and aIncReq pulses during oBusy cause no change.
REQ-036 Reset mid-operation: aReset_n=0 during RUN -> oScanEn, oIncrement and oBusy fall immediately, and no oDone is asserted.
